// File: rtl/collatz_seq_ctrl.sv
// collatz_seq_ctrl: steps a working value along its Collatz trajectory
// (even -> n/2, odd -> 3n+1), one parity decision and one update per clock,
// until the value reaches 1. Tracks total/odd/even step counts and the peak
// value, and reports overflow, timeout or zero input as an error with done.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, a          run request and start value, sampled only in IDLE
//   abort             synchronous cancel while running (no done pulse)
//   busy              high in RUN and DONE
//   done              one-cycle completion/error pulse
//   err, err_code     error flag and cause (01 overflow, 10 timeout, 11 zero)
//   cur               current working value
//   steps             completed update steps
//   odd_cnt, even_cnt steps taken on odd / even values
//   peak              largest value seen, including the start value
module collatz_seq_ctrl #(
  parameter int unsigned N         = 8,
  parameter int unsigned S         = 8,
  parameter int unsigned MAX_STEPS = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] a,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [N-1:0] cur,
  output logic [S-1:0] steps,
  output logic [S-1:0] odd_cnt,
  output logic [S-1:0] even_cnt,
  output logic [N-1:0] peak
);

  // Two extra bits hold 3n+1 for any N-bit n without loss.
  localparam int unsigned WX = N + 2;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_ZERO = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [WX-1:0] triple_c;
  logic          ovf_c;
  logic [N-1:0]  next_odd_c;
  logic          at_limit_c;

  // Odd-step candidate and its overflow check.
  assign triple_c   = WX'(cur) * WX'(3) + WX'(1);
  assign ovf_c      = |triple_c[WX-1:N];
  assign next_odd_c = triple_c[N-1:0];
  assign at_limit_c = (steps == S'(MAX_STEPS));

  // Sequencer with registered results and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      cur      <= '0;
      steps    <= '0;
      odd_cnt  <= '0;
      even_cnt <= '0;
      peak     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cur      <= a;
            peak     <= a;
            steps    <= '0;
            odd_cnt  <= '0;
            even_cnt <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cur == '0) begin
            err      <= 1'b1;
            err_code <= ERR_ZERO;
            done     <= 1'b1;
            state    <= DONE;
          end else if (cur == N'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (at_limit_c) begin
            err      <= 1'b1;
            err_code <= ERR_TMO;
            done     <= 1'b1;
            state    <= DONE;
          end else if (!cur[0]) begin
            cur      <= cur >> 1;
            even_cnt <= even_cnt + S'(1);
            steps    <= steps + S'(1);
          end else if (ovf_c) begin
            // Leave cur/steps/peak at the last representable value.
            err      <= 1'b1;
            err_code <= ERR_OVF;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cur     <= next_odd_c;
            odd_cnt <= odd_cnt + S'(1);
            steps   <= steps + S'(1);
            if (next_odd_c > peak) begin
              peak <= next_odd_c;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_seq_ctrl.sv
// Directed bench for collatz_seq_ctrl: a default instance (MAX_STEPS=200)
// and a short-limit instance (MAX_STEPS=5) for the timeout path.
module tb_collatz_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] a;
  logic       busy, done, err;
  logic [1:0] err_code;
  logic [7:0] cur, steps, odd_cnt, even_cnt, peak;

  logic       start2, abort2;
  logic [7:0] a2;
  logic       busy2, done2, err2;
  logic [1:0] err_code2;
  logic [7:0] cur2, steps2, odd_cnt2, even_cnt2, peak2;

  int n_tests;
  int n_fail;

  collatz_seq_ctrl #(.N(8), .S(8), .MAX_STEPS(200)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .cur(cur), .steps(steps), .odd_cnt(odd_cnt), .even_cnt(even_cnt),
    .peak(peak)
  );

  collatz_seq_ctrl #(.N(8), .S(8), .MAX_STEPS(5)) dut_tmo (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .a(a2),
    .busy(busy2), .done(done2), .err(err2), .err_code(err_code2),
    .cur(cur2), .steps(steps2), .odd_cnt(odd_cnt2), .even_cnt(even_cnt2),
    .peak(peak2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start on the main instance; the posedge in between is E0.
  task automatic kick(input logic [7:0] val);
    @(negedge clk);
    start = 1'b1;
    a     = val;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen; -1 if the bound expires.
  task automatic wait_done(input int limit, output int edges);
    edges = -1;
    for (int k = 0; k <= limit; k++) begin
      if (done) begin
        edges = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string tag, input logic [7:0] val,
                               input int exp_steps, input logic exp_err,
                               input logic [1:0] exp_code, input logic [7:0] exp_cur,
                               input logic [7:0] exp_odd, input logic [7:0] exp_even,
                               input logic [7:0] exp_peak);
    int edges;
    kick(val);
    wait_done(300, edges);
    check({tag, ".latency"}, 32'(edges), 32'(exp_steps + 1));
    check({tag, ".busy"},    32'(busy),     32'(1));
    check({tag, ".err"},     32'(err),      32'(exp_err));
    check({tag, ".code"},    32'(err_code), 32'(exp_code));
    check({tag, ".steps"},   32'(steps),    32'(exp_steps));
    check({tag, ".cur"},     32'(cur),      32'(exp_cur));
    check({tag, ".odd"},     32'(odd_cnt),  32'(exp_odd));
    check({tag, ".even"},    32'(even_cnt), 32'(exp_even));
    check({tag, ".peak"},    32'(peak),     32'(exp_peak));
    @(negedge clk);
    check({tag, ".done_off"}, 32'(done), 32'(0));
    check({tag, ".idle"},     32'(busy), 32'(0));
    check({tag, ".hold"},     32'(steps), 32'(exp_steps));
  endtask

  initial begin
    int edges;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; a = '0;
    start2 = 1'b0; abort2 = 1'b0; a2 = '0;

    // Reset state
    #12;
    check("rst.busy",  32'(busy),     32'(0));
    check("rst.done",  32'(done),     32'(0));
    check("rst.err",   32'(err),      32'(0));
    check("rst.code",  32'(err_code), 32'(0));
    check("rst.cur",   32'(cur),      32'(0));
    check("rst.steps", 32'(steps),    32'(0));
    check("rst.peak",  32'(peak),     32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 6,3,10,5,16,8,4,2,1
    run_and_check("a6", 8'd6, 8, 1'b0, 2'b00, 8'd1, 8'd2, 8'd6, 8'd16);
    run_and_check("a1", 8'd1, 0, 1'b0, 2'b00, 8'd1, 8'd0, 8'd0, 8'd1);
    run_and_check("a0", 8'd0, 0, 1'b1, 2'b11, 8'd0, 8'd0, 8'd0, 8'd0);
    // 27 ... 214 -> 107, then 3*107+1=322 overflows 8 bits
    run_and_check("a27", 8'd27, 11, 1'b1, 2'b01, 8'd107, 8'd5, 8'd6, 8'd214);

    // Timeout with MAX_STEPS=5: 6,3,10,5,16,8
    @(negedge clk);
    start2 = 1'b1; a2 = 8'd6;
    @(negedge clk);
    start2 = 1'b0;
    edges = -1;
    for (int k = 0; k <= 50; k++) begin
      if (done2) begin
        edges = k;
        break;
      end
      @(negedge clk);
    end
    check("tmo.latency", 32'(edges),     32'(6));
    check("tmo.err",     32'(err2),      32'(1));
    check("tmo.code",    32'(err_code2), 32'(2));
    check("tmo.steps",   32'(steps2),    32'(5));
    check("tmo.cur",     32'(cur2),      32'(8));
    check("tmo.peak",    32'(peak2),     32'(16));

    // Abort with a=7 (7,22,11,34,17,52); a restart at step 3 is ignored
    kick(8'd7);
    repeat (3) @(negedge clk);
    check("abt.s3", 32'(steps), 32'(3));
    start = 1'b1; a = 8'd99;
    @(negedge clk);
    start = 1'b0;
    check("abt.s4", 32'(steps), 32'(4));
    check("abt.cur4", 32'(cur), 32'(17));
    @(negedge clk);
    check("abt.s5", 32'(steps), 32'(5));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abt.busy",  32'(busy),  32'(0));
    check("abt.done",  32'(done),  32'(0));
    check("abt.steps", 32'(steps), 32'(5));
    check("abt.cur",   32'(cur),   32'(52));
    check("abt.peak",  32'(peak),  32'(52));
    @(negedge clk);
    check("abt.nodone", 32'(done), 32'(0));

    // Asynchronous reset mid-run with a=9
    kick(8'd9);
    repeat (3) @(negedge clk);
    check("mid.busy_pre", 32'(busy), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.busy",  32'(busy),     32'(0));
    check("mid.cur",   32'(cur),      32'(0));
    check("mid.steps", 32'(steps),    32'(0));
    check("mid.odd",   32'(odd_cnt),  32'(0));
    check("mid.even",  32'(even_cnt), 32'(0));
    check("mid.peak",  32'(peak),     32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("a2", 8'd2, 1, 1'b0, 2'b00, 8'd1, 8'd0, 8'd1, 8'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
